// File: rtl/ysyx_25060170_mem_pkg.sv
// Shared definitions for the data-memory request/response path, used by the
// responder and by lsu-side requesters alike.
package ysyx_25060170_mem_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = 8;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/ysyx_25060170_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded to 8'hA5 on rst, stepping once per en.
// Only the low two bits are exported; they jitter the response latency.
module ysyx_25060170_lfsr8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [1:0] rnd
);

    logic [7:0] q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 8'hA5;
        end else if (en) begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

    assign rnd = q[1:0];

endmodule

// File: rtl/ysyx_25060170_dmem_resp.sv
// Single-outstanding 64-bit data memory responder with fixed or jittered latency.
// Define YSYX_25060170_DMEM_RAND_DELAY_EN to add 0..3 LFSR-driven extra wait cycles.
module ysyx_25060170_dmem_resp
    import ysyx_25060170_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    dmem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  lat_eff;
    logic              accept;

    logic              wen_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic              acc_fire;
    logic              acc_wen;
    logic [31:0]       acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [STRB_W-1:0] acc_wstrb;
    logic [31:0]       acc_off;
    logic              acc_in_win;
    logic [ADDR_W-1:0] acc_idx;

    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    assign accept = (state_q == IDLE) && req_valid;

`ifdef YSYX_25060170_DMEM_RAND_DELAY_EN
    logic [1:0] rnd;

    // The LFSR steps on the accept edge, so L uses the value from before the step.
    ysyx_25060170_lfsr8 u_lfsr8 (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .rnd (rnd)
    );

    assign lat_eff = CNT_W'(LATENCY) + CNT_W'(rnd);
`else
    assign lat_eff = CNT_W'(LATENCY);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = lat_eff;
                    state_d = (lat_eff == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (accept) begin
            wen_q   <= req_wen;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
    end

    // A zero-latency access uses the live request; otherwise the latched copy
    // is used on the last WAIT cycle.
    always_comb begin
        acc_fire  = 1'b0;
        acc_wen   = wen_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_wstrb = wstrb_q;
        if (state_q == IDLE && accept && lat_eff == '0) begin
            acc_fire  = 1'b1;
            acc_wen   = req_wen;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_wstrb = req_wstrb;
        end else if (state_q == WAIT && cnt_q <= CNT_W'(1)) begin
            acc_fire = 1'b1;
        end
    end

    assign acc_off    = acc_addr - BASE;
    assign acc_in_win = (acc_addr >= BASE) && ((acc_off >> (ADDR_W + 3)) == 32'd0);
    assign acc_idx    = acc_off[ADDR_W+2:3];

    always_ff @(posedge clk) begin
        if (!rst && acc_fire && acc_wen && acc_in_win) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (acc_wstrb[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (acc_fire) begin
            err_q   <= !acc_in_win;
            rdata_q <= (!acc_wen && acc_in_win) ? mem[acc_idx] : '0;
        end else if (state_q == RESP && resp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_25060170_dmem_resp.sv
// Randomised self-checking bench for ysyx_25060170_dmem_resp against a word-array model.
// Honours YSYX_25060170_DMEM_RAND_DELAY_EN when the design is built with it.
module tb_ysyx_25060170_dmem_resp;

`ifdef YSYX_25060170_DMEM_RAND_DELAY_EN
    localparam int unsigned LAT = 0;
`else
    localparam int unsigned LAT = 1;
`endif
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int unsigned ADDR_W = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [63:0] model [longint unsigned];

    ysyx_25060170_dmem_resp #(
        .ADDR_W  (ADDR_W),
        .BASE    (BASE),
        .LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [7:0] st);
        logic [63:0] r = old;
        for (int i = 0; i < 8; i++) if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic check_lat(input int unsigned lat);
`ifdef YSYX_25060170_DMEM_RAND_DELAY_EN
        chk("lat_range", 64'(lat >= LAT + 1 && lat <= LAT + 4), 64'd1);
`else
        chk("latency", 64'(lat), 64'(LAT + 1));
`endif
    endtask

    task automatic txn(input logic wen, input logic [31:0] addr, input logic [63:0] wd,
                       input logic [7:0] st, input int unsigned hold,
                       output logic [63:0] rd, output logic err, output int unsigned lat);
        int unsigned guard = 0;
        rd = '0; err = 1'b0; lat = 0;
        req_wen = wen; req_addr = addr; req_wdata = wd; req_wstrb = st; req_valid = 1'b1;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_wdata = '0; req_wstrb = '0;
        lat = 1;
        while (!resp_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (!resp_valid) begin
            chk("resp_timeout", 64'd0, 64'd1);
            return;
        end
        rd  = resp_rdata;
        err = resp_err;
        for (int unsigned i = 0; i < hold; i++) begin
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_rdata", resp_rdata, rd);
            chk("hold_err", 64'(resp_err), 64'(err));
            chk("hold_req_ready", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("back_idle", 64'(req_ready), 64'd1);
    endtask

    // Expected values come from the window rule and the word-array model.
    task automatic do_check(input string tag, input logic wen, input logic [31:0] addr,
                            input logic [63:0] wd, input logic [7:0] st, input int unsigned hold);
        logic [63:0]     rd;
        logic            err;
        int unsigned     lat;
        longint unsigned a    = longint'(addr);
        longint unsigned lo   = longint'(BASE);
        longint unsigned hi   = lo + 8 * (64'd1 << ADDR_W);
        bit              inwin = (a >= lo) && (a < hi);
        longint unsigned widx = (a - lo) >> 3;
        logic [63:0]     exp_rd = '0;
        if (inwin && !wen) exp_rd = model.exists(widx) ? model[widx] : '0;
        txn(wen, addr, wd, st, hold, rd, err, lat);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, 64'(err), 64'(!inwin));
        check_lat(lat);
        if (inwin && wen) model[widx] = merge(model.exists(widx) ? model[widx] : '0, wd, st);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        resp_ready = 1'b0;
        @(negedge clk);
        pulse_rst();
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_err", 64'(resp_err), 64'd0);

        do_check("st_full", 1'b1, 32'h8000_0010, 64'h1122334455667788, 8'hFF, 0);
        do_check("ld_full", 1'b0, 32'h8000_0010, '0, '0, 0);
        do_check("sb_lane3", 1'b1, 32'h8000_0013, 64'h0000_0000_AB00_0000, 8'h08, 0);
        do_check("ld_merged", 1'b0, 32'h8000_0010, '0, '0, 0);
        chk("merged_const", model[2], 64'h11223344AB667788);
        do_check("st_nostrb", 1'b1, 32'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0);
        do_check("ld_nostrb", 1'b0, 32'h8000_0010, '0, '0, 0);

        do_check("st_base", 1'b1, 32'h8000_0000, 64'hCAFE_F00D_1234_5678, 8'hFF, 0);
        do_check("ld_below", 1'b0, 32'h7FFF_FFF8, '0, '0, 0);
        do_check("st_above", 1'b1, 32'h8000_8000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0);
        do_check("st_wrapidx", 1'b1, 32'h8000_8000 + 32'h0, 64'h5555_5555_5555_5555, 8'hFF, 1);
        do_check("ld_base", 1'b0, 32'h8000_0000, '0, '0, 0);
        do_check("st_last", 1'b1, 32'h8000_7FF8, 64'h0102_0304_0506_0708, 8'hFF, 0);
        do_check("ld_last", 1'b0, 32'h8000_7FFF, '0, '0, 0);

        do_check("ld_hold5", 1'b0, 32'h8000_0010, '0, '0, 5);

`ifndef YSYX_25060170_DMEM_RAND_DELAY_EN
        do_check("st_old", 1'b1, 32'h8000_0020, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, 0);
        req_wen = 1'b1; req_addr = 32'h8000_0020; req_wdata = 64'h7777_7777_7777_7777;
        req_wstrb = 8'hFF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("wait_no_resp", 64'(resp_valid), 64'd0);
        chk("wait_not_ready", 64'(req_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_wait_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk("rst_wait_no_resp", 64'(resp_valid), 64'd0);
            @(posedge clk); #1;
        end
        do_check("ld_after_rst", 1'b0, 32'h8000_0020, '0, '0, 0);
`endif

        for (int k = 0; k < 16; k++)
            do_check("rnd_init", 1'b1, 32'h8000_0100 + 32'(8 * k),
                     {$urandom, $urandom}, 8'hFF, 0);
        for (int n = 0; n < 40; n++) begin
            int unsigned r = $urandom_range(0, 19);
            logic [31:0] a;
            if (r < 16) a = 32'h8000_0100 + 32'(8 * r) + 32'($urandom_range(0, 7));
            else if (r < 18) a = 32'h7FFF_FFF0 + 32'($urandom_range(0, 7));
            else a = 32'h8000_8008 + 32'($urandom_range(0, 7));
            do_check("rnd", 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                     8'($urandom), $urandom_range(0, 2));
        end

`ifdef YSYX_25060170_DMEM_RAND_DELAY_EN
        begin
            int unsigned lat_a [20];
            logic [63:0] rd;
            logic        err;
            int unsigned lat;
            pulse_rst();
            for (int i = 0; i < 20; i++) begin
                txn(1'b0, 32'h8000_0010, '0, '0, 0, rd, err, lat);
                lat_a[i] = lat;
                check_lat(lat);
            end
            pulse_rst();
            for (int i = 0; i < 20; i++) begin
                txn(1'b0, 32'h8000_0010, '0, '0, 0, rd, err, lat);
                chk("lat_repro", 64'(lat), 64'(lat_a[i]));
            end
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
